// File: rtl/ram_loader.sv
// ram_loader: streams LOAD_LEN bytes from a valid/ready source into the program RAM,
// starting at address 0, and holds the CPU halted for the duration of the load.
// Optional feature macro: VERIFY_EN adds a readback sweep that re-sums the RAM
// contents and flags a mismatch against the load checksum on 'error'.
// RAM outputs come from rising-edge registers so they are stable at the RAM's
// falling-edge commit.
module ram_loader #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned LOAD_LEN = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_spo,
    output logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(LOAD_LEN - 1);

`ifdef VERIFY_EN
    typedef enum logic [1:0] {StIdle, StLoad, StVerify} state_e;
    // Verify counter runs 0..LOAD_LEN, one extra cycle to collect the last read.
    localparam logic [ADDR_W:0] VcntLast = (ADDR_W + 1)'(LOAD_LEN);
`else
    typedef enum logic [1:0] {StIdle, StLoad} state_e;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [DATA_W-1:0] ram_d_q, ram_d_d;
    logic              ram_we_q, ram_we_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic              xfer;

`ifdef VERIFY_EN
    logic              error_q, error_d;
    logic [ADDR_W:0]   vcnt_q, vcnt_d;
    logic [DATA_W-1:0] vsum_q, vsum_d;
`else
    // Marks the cycle after the last write so done rises one edge later.
    logic              fin_q, fin_d;
    logic              unused_spo;
    assign unused_spo = ^ram_spo;
`endif

    assign in_ready = (state_q == StLoad);
    assign xfer     = in_valid & in_ready;

    // Next-state and datapath update for the load/verify sequencer.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ram_a_d    = ram_a_q;
        ram_d_d    = ram_d_q;
        ram_we_d   = 1'b0;
        done_d     = done_q;
        checksum_d = checksum_q;
`ifdef VERIFY_EN
        error_d    = error_q;
        vcnt_d     = vcnt_q;
        vsum_d     = vsum_q;
`else
        fin_d      = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
`ifndef VERIFY_EN
                if (fin_q) begin
                    done_d = 1'b1;
                end
`endif
                if (start) begin
                    state_d    = StLoad;
                    addr_d     = '0;
                    checksum_d = '0;
                    done_d     = 1'b0;
`ifdef VERIFY_EN
                    error_d    = 1'b0;
`endif
                end
            end
            StLoad: begin
                if (xfer) begin
                    ram_a_d    = addr_q;
                    ram_d_d    = in_data;
                    ram_we_d   = 1'b1;
                    checksum_d = checksum_q + in_data;
                    if (addr_q == LastAddr) begin
`ifdef VERIFY_EN
                        state_d = StVerify;
                        vcnt_d  = '0;
                        vsum_d  = '0;
`else
                        state_d = StIdle;
                        fin_d   = 1'b1;
`endif
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
`ifdef VERIFY_EN
            StVerify: begin
                // spo reflects the address driven on the previous edge.
                if (vcnt_q != '0) begin
                    vsum_d = vsum_q + ram_spo;
                end
                if (vcnt_q == VcntLast) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    error_d = (vsum_d != checksum_q);
                end else begin
                    ram_a_d = vcnt_q[ADDR_W-1:0];
                    vcnt_d  = vcnt_q + 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            ram_a_q    <= '0;
            ram_d_q    <= '0;
            ram_we_q   <= 1'b0;
            done_q     <= 1'b0;
            checksum_q <= '0;
`ifdef VERIFY_EN
            error_q    <= 1'b0;
            vcnt_q     <= '0;
            vsum_q     <= '0;
`else
            fin_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ram_a_q    <= ram_a_d;
            ram_d_q    <= ram_d_d;
            ram_we_q   <= ram_we_d;
            done_q     <= done_d;
            checksum_q <= checksum_d;
`ifdef VERIFY_EN
            error_q    <= error_d;
            vcnt_q     <= vcnt_d;
            vsum_q     <= vsum_d;
`else
            fin_q      <= fin_d;
`endif
        end
    end

    assign ram_a    = ram_a_q;
    assign ram_d    = ram_d_q;
    assign ram_we   = ram_we_q;
    assign cpu_halt = (state_q != StIdle);
    assign busy     = cpu_halt;
    assign done     = done_q;
    assign checksum = checksum_q;
`ifdef VERIFY_EN
    assign error    = error_q;
`else
    assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: scoreboard bench for ram_loader with falling-edge RAM models.
// A 16-word instance covers the main load cases; a 4-word instance covers short loads.
`timescale 1ns/1ps
module tb_ram_loader;

    localparam int unsigned LEN  = 16;
    localparam int unsigned LEN4 = 4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, in_valid, in_ready, ram_we, cpu_halt, busy, done, error;
    logic [7:0] in_data, ram_d, ram_spo, checksum;
    logic [3:0] ram_a;

    logic       start4, in_valid4, ready4, ram4_we, halt4, busy4, done4, error4;
    logic [7:0] in_data4, ram4_d, ram4_spo, checksum4;
    logic [3:0] ram4_a;

    logic [7:0] mem  [16];
    logic [7:0] mem4 [16];
    logic [7:0] spo, spo4;
    logic       ram_clr, flip_en;

    logic [7:0] pattern [16] = '{8'h51, 8'h4E, 8'h3A, 8'hC7, 8'h12, 8'hFF, 8'h80, 8'h6D,
                                 8'h29, 8'hB4, 8'h05, 8'hE3, 8'h77, 8'h9A, 8'h41, 8'h00};

    ram_loader #(.ADDR_W(4), .DATA_W(8), .LOAD_LEN(LEN)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we),
        .ram_spo(ram_spo), .cpu_halt(cpu_halt), .busy(busy), .done(done), .error(error),
        .checksum(checksum)
    );

    ram_loader #(.ADDR_W(4), .DATA_W(8), .LOAD_LEN(LEN4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(ready4), .ram_a(ram4_a), .ram_d(ram4_d), .ram_we(ram4_we),
        .ram_spo(ram4_spo), .cpu_halt(halt4), .busy(busy4), .done(done4), .error(error4),
        .checksum(checksum4)
    );

    // A single-bit fault on reads of address 3 when flip_en is set.
    assign ram_spo  = spo ^ ((flip_en && ram_a == 4'd3) ? 8'h04 : 8'h00);
    assign ram4_spo = spo4;

    // RAM models: write and read port update on the falling edge.
    always @(negedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16; i++) begin
                mem[i]  <= 8'hEE;
                mem4[i] <= 8'hEE;
            end
        end else begin
            if (ram_we) mem[ram_a] <= ram_d;
            if (ram4_we) mem4[ram4_a] <= ram4_d;
        end
        spo  <= ram_we ? ram_d : mem[ram_a];
        spo4 <= ram4_we ? ram4_d : mem4[ram4_a];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard of expected writes {addr, data}.
    logic [11:0] exp_q [$];
    logic [11:0] mon_e;
    logic [3:0]  exp_addr;
    logic [7:0]  exp_sum;
    int          we_cnt, we4_cnt;

    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_we", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", ram_a, mon_e[11:8]);
                check("wr_data", ram_d, mon_e[7:0]);
            end
        end
        if (ram4_we) we4_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ram();
        ram_clr = 1'b1;
        @(negedge clk);
        #1;
        ram_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            check("ready_timeout", 0, 1);
        end else begin
            exp_q.push_back({exp_addr, b});
            exp_addr++;
            exp_sum += b;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        check("done_set", done, 1);
    endtask

    // mode 0: back-to-back, 1: valid toggling, 2: stray start at byte 5.
    task automatic run_load(input int mode, input logic exp_err);
        exp_addr = '0;
        exp_sum  = '0;
        we_cnt   = 0;
        clear_ram();
        tick();
        pulse_start();
        check("halt_in_load", cpu_halt, 1);
        check("busy_in_load", busy, 1);
        check("ready_in_load", in_ready, 1);
        check("done_cleared", done, 0);
        check("error_cleared", error, 0);
        for (int i = 0; i < LEN; i++) begin
            if (mode == 2 && i == 5) start = 1'b1;
            send_byte(pattern[i]);
            start = 1'b0;
            if (mode == 1) tick();
        end
        wait_done();
        check("checksum", checksum, exp_sum);
        check("halt_after", cpu_halt, 0);
        check("busy_after", busy, 0);
        check("ready_after", in_ready, 0);
        check("we_count", we_cnt, LEN);
        check("queue_empty", exp_q.size(), 0);
        check("error_flag", error, exp_err);
        for (int i = 0; i < LEN; i++) check("ram_word", mem[i], pattern[i]);
        repeat (3) tick();
        check("done_hold", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] sum4;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        start4 = 1'b0; in_valid4 = 1'b0; in_data4 = '0;
        ram_clr = 1'b0; flip_en = 1'b0;
        we_cnt = 0; we4_cnt = 0;
        clear_ram();
        tick();
        tick();
        check("rst_we", ram_we, 0);
        check("rst_a", ram_a, 0);
        check("rst_d", ram_d, 0);
        check("rst_halt", cpu_halt, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_sum", checksum, 0);
        check("rst_ready", in_ready, 0);
        reset = 1'b0;
        tick();
        check("idle_ready", in_ready, 0);

        run_load(0, 1'b0);
        run_load(1, 1'b0);
        run_load(2, 1'b0);

`ifdef VERIFY_EN
        flip_en = 1'b1;
        run_load(0, 1'b1);
        flip_en = 1'b0;
        run_load(0, 1'b0);
`endif

        // Reset after the 7th byte of a load with different data.
        exp_addr = '0;
        exp_sum  = '0;
        clear_ram();
        tick();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(pattern[i] ^ 8'hA5);
        reset = 1'b1;
        tick();
        check("mid_rst_we", ram_we, 0);
        check("mid_rst_a", ram_a, 0);
        check("mid_rst_d", ram_d, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_halt", cpu_halt, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_sum", checksum, 0);
        check("mid_rst_ready", in_ready, 0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", in_ready, 0);
        check("post_rst_halt", cpu_halt, 0);
        check("post_rst_queue", exp_q.size(), 0);
        for (int i = 0; i < 7; i++) check("rst_ram_kept", mem[i], pattern[i] ^ 8'hA5);
        for (int i = 7; i < 16; i++) check("rst_ram_untouched", mem[i], 8'hEE);

        // Four-word instance.
        clear_ram();
        we4_cnt = 0;
        sum4 = '0;
        tick();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("len4_halt", halt4, 1);
        for (int i = 0; i < LEN4; i++) begin
            check("len4_ready", ready4, 1);
            in_data4  = pattern[i] ^ 8'h3C;
            in_valid4 = 1'b1;
            sum4 += pattern[i] ^ 8'h3C;
            tick();
        end
        check("len4_ready_off", ready4, 0);
        tick();
        in_valid4 = 1'b0;
        for (int n = 0; n < 40 && !done4; n++) tick();
        check("len4_done", done4, 1);
        check("len4_halt_off", halt4, 0);
        check("len4_we_count", we4_cnt, LEN4);
        check("len4_checksum", checksum4, sum4);
        check("len4_error", error4, 0);
        for (int i = 0; i < LEN4; i++) check("len4_ram", mem4[i], pattern[i] ^ 8'h3C);
        for (int i = LEN4; i < 16; i++) check("len4_ram_untouched", mem4[i], 8'hEE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
